// File: rtl/video_axis_pkg.sv
// video_axis_pkg: shared state encoding, tdata slicing and error bit indices
package video_axis_pkg;
    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DISCARD} state_t;
    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;
    localparam int ERR_SOF       = 0;
    localparam int ERR_EOL_EARLY = 1;
    localparam int ERR_EOL_LATE  = 2;
    localparam int ERR_W         = 3;
endpackage

// File: rtl/video_hv_counter.sv
// video_hv_counter: pixel/line position counter with exact wrap points
module video_hv_counter #(
    parameter int H_pixel = 1280,
    parameter int V_line  = 960,
    parameter int CNT_W   = 12
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             inc,
    input  logic             restart,
    input  logic             clear,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             last_pix,
    output logic             last_line
);
    assign last_pix  = h_cnt == CNT_W'(H_pixel - 1);
    assign last_line = v_cnt == CNT_W'(V_line - 1);
    // restart loads the position just after pixel (0,0), which was consumed by the SOF beat
    always_ff @(posedge Clk) begin
        if (Rst || clear) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (restart) begin
            h_cnt <= CNT_W'(1);
            v_cnt <= '0;
        end else if (inc) begin
            h_cnt <= last_pix ? '0 : h_cnt + 1'b1;
            v_cnt <= last_pix ? (last_line ? '0 : v_cnt + 1'b1) : v_cnt;
        end
    end
endmodule

// File: rtl/axis_video_line_splitter.sv
// axis_video_line_splitter: checks AXIS frame geometry, steers even rows to FIFO 0 and odd rows to FIFO 1
module axis_video_line_splitter
    import video_axis_pkg::*;
#(
    parameter int H_pixel = 1280,
    parameter int V_line  = 960,
    parameter int CNT_W   = 12
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [23:0] s_axis_video_tdata,
    input  logic        s_axis_video_tvalid,
    output logic        s_axis_video_tready,
    input  logic        s_axis_video_tuser,
    input  logic        s_axis_video_tlast,
    input  logic [2:0]  s_axis_video_tkeep,
    output logic [7:0]  fifo_wdata_r,
    output logic [7:0]  fifo_wdata_g,
    output logic [7:0]  fifo_wdata_b,
    output logic        fifo_wea_0,
    output logic        fifo_wea_1,
    input  logic        fifo_full_0,
    input  logic        fifo_full_1,
    output logic        line_done,
    output logic        frame_done,
    output logic        wr_done_sig,
    output logic        err_sof,
    output logic        err_eol_early,
    output logic        err_eol_late,
    input  logic        err_clr
);
    state_t             state, nxt;
    logic [CNT_W-1:0]   h_cnt, v_cnt;
    logic               last_pix, last_line, inc, restart, clear;
    logic               tgt, full_t, accept, write, ld_set, fd_set, unused_keep;
    logic [ERR_W-1:0]   err, err_set;

    video_hv_counter #(.H_pixel(H_pixel), .V_line(V_line), .CNT_W(CNT_W)) u_cnt (
        .Clk(Clk), .Rst(Rst), .inc(inc), .restart(restart), .clear(clear),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .last_pix(last_pix), .last_line(last_line)
    );

    // an SOF beat always lands in FIFO 0, so its flag gates ready even on an odd row
    assign tgt                 = (state == ACTIVE) & ~s_axis_video_tuser & v_cnt[0];
    assign full_t              = tgt ? fifo_full_1 : fifo_full_0;
    assign s_axis_video_tready = ~Rst & ((state == DISCARD & ~s_axis_video_tuser) | ~full_t);
    assign accept              = s_axis_video_tvalid & s_axis_video_tready;
    assign write               = accept & (state == ACTIVE | s_axis_video_tuser);
    assign fifo_wea_0          = write & ~tgt;
    assign fifo_wea_1          = write & tgt;
    assign fifo_wdata_r        = s_axis_video_tdata[R_MSB:R_LSB];
    assign fifo_wdata_g        = s_axis_video_tdata[G_MSB:G_LSB];
    assign fifo_wdata_b        = s_axis_video_tdata[B_MSB:B_LSB];
    assign err_sof             = err[ERR_SOF];
    assign err_eol_early       = err[ERR_EOL_EARLY];
    assign err_eol_late        = err[ERR_EOL_LATE];
    assign unused_keep         = ^s_axis_video_tkeep;

    always_comb begin
        nxt     = state;
        inc     = 1'b0;
        restart = 1'b0;
        clear   = 1'b0;
        ld_set  = 1'b0;
        fd_set  = 1'b0;
        err_set = '0;
        if (accept) begin
            case (state)
                ACTIVE: begin
                    if (s_axis_video_tuser && |{h_cnt, v_cnt}) begin
                        err_set[ERR_SOF] = 1'b1;
                        restart          = 1'b1;
                    end else if (s_axis_video_tlast && !last_pix) begin
                        err_set[ERR_EOL_EARLY] = 1'b1;
                        clear                  = 1'b1;
                        nxt                    = WAIT_SOF;
                    end else if (last_pix && !s_axis_video_tlast) begin
                        err_set[ERR_EOL_LATE] = 1'b1;
                        nxt                   = DISCARD;
                    end else begin
                        inc    = 1'b1;
                        ld_set = last_pix;
                        fd_set = last_pix & last_line;
                        nxt    = (last_pix && last_line) ? WAIT_SOF : ACTIVE;
                    end
                end
                default: begin
                    restart = s_axis_video_tuser;
                    clear   = (state == DISCARD) & ~s_axis_video_tuser & s_axis_video_tlast;
                    nxt     = s_axis_video_tuser ? ACTIVE : (clear ? WAIT_SOF : state);
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= WAIT_SOF;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            wr_done_sig <= 1'b0;
            err         <= '0;
        end else begin
            state       <= nxt;
            line_done   <= ld_set;
            frame_done  <= fd_set;
            wr_done_sig <= last_line & (state == ACTIVE);
            err         <= (err & ~{ERR_W{err_clr}}) | err_set;
        end
    end
endmodule

// File: tb/tb_axis_video_line_splitter.sv
// tb_axis_video_line_splitter: scoreboard bench for the line splitter at 8x4 geometry
module tb_axis_video_line_splitter;
    import video_axis_pkg::*;
    localparam int H = 8;
    localparam int V = 4;

    logic        Clk = 1'b0, Rst = 1'b1;
    logic [23:0] tdata = '0;
    logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0, tready;
    logic [2:0]  tkeep = '1;
    logic [7:0]  wr, wg, wb;
    logic        wea0, wea1, full0 = 1'b0, full1 = 1'b0;
    logic        line_done, frame_done, wr_done, e_sof, e_early, e_late, err_clr = 1'b0;
    int          assertions = 0, failures = 0, n_line = 0, n_frame = 0;
    int          qf[$];
    logic [23:0] qd[$];

    always #5 Clk = ~Clk;

    axis_video_line_splitter #(.H_pixel(H), .V_line(V), .CNT_W(12)) dut (
        .Clk(Clk), .Rst(Rst),
        .s_axis_video_tdata(tdata), .s_axis_video_tvalid(tvalid), .s_axis_video_tready(tready),
        .s_axis_video_tuser(tuser), .s_axis_video_tlast(tlast), .s_axis_video_tkeep(tkeep),
        .fifo_wdata_r(wr), .fifo_wdata_g(wg), .fifo_wdata_b(wb),
        .fifo_wea_0(wea0), .fifo_wea_1(wea1), .fifo_full_0(full0), .fifo_full_1(full1),
        .line_done(line_done), .frame_done(frame_done), .wr_done_sig(wr_done),
        .err_sof(e_sof), .err_eol_early(e_early), .err_eol_late(e_late), .err_clr(err_clr)
    );

    // every FIFO write must match the oldest expected (fifo, pixel) pair
    always @(negedge Clk) begin
        int          f;
        logic [23:0] d;
        if (line_done) n_line++;
        if (frame_done) n_frame++;
        if (wea0 | wea1) begin
            assertions++;
            if (wea0 & wea1) begin
                failures++;
                $display("FAIL wea_both: both write enables high, expected one");
            end else if (qf.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: fifo%0d data %h, expected no write", wea1, {wr, wg, wb});
            end else begin
                f = qf.pop_front();
                d = qd.pop_front();
                if (f != int'(wea1) || {wr, wg, wb} !== d) begin
                    failures++;
                    $display("FAIL write: got fifo%0d %h, expected fifo%0d %h", wea1, {wr, wg, wb}, f, d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic beat(input logic u, input logic l, input int f);
        int n = 0;
        tdata  = 24'($urandom);
        tuser  = u;
        tlast  = l;
        tvalid = 1'b1;
        if (f >= 0) begin
            qf.push_back(f);
            qd.push_back(tdata);
        end
        @(negedge Clk);
        while (!tready && n < 50) begin
            n++;
            @(negedge Clk);
        end
        if (!tready) begin
            assertions++;
            failures++;
            $display("FAIL beat_timeout: tready 0, expected 1");
        end
        @(posedge Clk);
        #1;
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_row(input int r, input int c0);
        for (int c = c0; c < H; c++) beat(r == 0 && c == 0, c == H - 1, r % 2);
    endtask

    task automatic send_frame();
        for (int r = 0; r < V; r++) send_row(r, 0);
    endtask

    task automatic prep();
        err_clr = 1'b1;
        @(posedge Clk);
        #1;
        err_clr = 1'b0;
        n_line  = 0;
        n_frame = 0;
    endtask

    task automatic settle();
        @(negedge Clk);
        #1;
    endtask

    task automatic test_reset();
        tvalid = 1'b1;
        tuser  = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        assertions++; if (tready !== 1'b0) begin failures++; $display("FAIL reset_tready: got %b, expected 0", tready); end
        assertions++; if ({wea0, wea1} !== 2'b00) begin failures++; $display("FAIL reset_wea: got %b, expected 00", {wea0, wea1}); end
        assertions++; if ({e_sof, e_early, e_late} !== 3'b000) begin failures++; $display("FAIL reset_err: got %b, expected 000", {e_sof, e_early, e_late}); end
        assertions++; if ({line_done, frame_done, wr_done} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got %b, expected 000", {line_done, frame_done, wr_done}); end
        assertions++; if (dut.state !== WAIT_SOF) begin failures++; $display("FAIL reset_state: got %0d, expected WAIT_SOF", dut.state); end
        tvalid = 1'b0;
        tuser  = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_clean_frame();
        prep();
        for (int r = 0; r < V - 1; r++) send_row(r, 0);
        beat(1'b0, 1'b0, 1);
        assertions++; if (wr_done !== 1'b1) begin failures++; $display("FAIL clean_wr_done: got %b, expected 1", wr_done); end
        for (int c = 1; c < H; c++) beat(1'b0, c == H - 1, 1);
        @(negedge Clk);
        assertions++; if (frame_done !== 1'b1) begin failures++; $display("FAIL clean_frame_done_timing: got %b, expected 1", frame_done); end
        #1;
        assertions++; if (n_line != 4) begin failures++; $display("FAIL clean_line_done: got %0d, expected 4", n_line); end
        assertions++; if (n_frame != 1) begin failures++; $display("FAIL clean_frame_count: got %0d, expected 1", n_frame); end
        assertions++; if ({e_sof, e_early, e_late} !== 3'b000) begin failures++; $display("FAIL clean_err: got %b, expected 000", {e_sof, e_early, e_late}); end
        assertions++; if (qf.size() != 0) begin failures++; $display("FAIL clean_missing: %0d writes outstanding, expected 0", qf.size()); end
    endtask

    task automatic test_drop_no_sof();
        prep();
        repeat (5) beat(1'b0, 1'b0, -1);
        send_frame();
        settle();
        assertions++; if (n_frame != 1 || n_line != 4) begin failures++; $display("FAIL nosof_counts: got %0d/%0d, expected 1/4", n_frame, n_line); end
        assertions++; if (qf.size() != 0) begin failures++; $display("FAIL nosof_missing: %0d outstanding, expected 0", qf.size()); end
    endtask

    task automatic test_eol_early();
        prep();
        send_row(0, 0);
        for (int c = 0; c < 4; c++) beat(1'b0, 1'b0, 1);
        err_clr = 1'b1;
        beat(1'b0, 1'b1, 1);
        err_clr = 1'b0;
        assertions++; if (e_early !== 1'b1) begin failures++; $display("FAIL early_flag: got %b, expected 1", e_early); end
        assertions++; if (dut.state !== WAIT_SOF) begin failures++; $display("FAIL early_state: got %0d, expected WAIT_SOF", dut.state); end
        assertions++; if (dut.h_cnt !== 12'd0 || dut.v_cnt !== 12'd0) begin failures++; $display("FAIL early_cnt: got %0d,%0d, expected 0,0", dut.h_cnt, dut.v_cnt); end
        settle();
        assertions++; if (n_line != 1) begin failures++; $display("FAIL early_line_done: got %0d, expected 1", n_line); end
        send_frame();
        settle();
        assertions++; if (n_frame != 1 || qf.size() != 0) begin failures++; $display("FAIL early_recover: frames %0d outstanding %0d, expected 1 0", n_frame, qf.size()); end
    endtask

    task automatic test_eol_late();
        prep();
        for (int c = 0; c < H; c++) beat(c == 0, 1'b0, 0);
        beat(1'b0, 1'b0, -1);
        beat(1'b0, 1'b0, -1);
        beat(1'b0, 1'b1, -1);
        settle();
        assertions++; if (e_late !== 1'b1 || e_early !== 1'b0) begin failures++; $display("FAIL late_flags: got late %b early %b, expected 1 0", e_late, e_early); end
        assertions++; if (n_line != 0) begin failures++; $display("FAIL late_line_done: got %0d, expected 0", n_line); end
        assertions++; if (dut.state !== WAIT_SOF) begin failures++; $display("FAIL late_state: got %0d, expected WAIT_SOF", dut.state); end
        assertions++; if (qf.size() != 0) begin failures++; $display("FAIL late_missing: %0d outstanding, expected 0", qf.size()); end
    endtask

    task automatic test_sof_mid();
        prep();
        send_row(0, 0);
        send_row(1, 0);
        for (int c = 0; c < 3; c++) beat(1'b0, 1'b0, 0);
        beat(1'b1, 1'b0, 0);
        assertions++; if (e_sof !== 1'b1) begin failures++; $display("FAIL sof_flag: got %b, expected 1", e_sof); end
        for (int c = 1; c < H; c++) beat(1'b0, c == H - 1, 0);
        for (int r = 1; r < V; r++) send_row(r, 0);
        settle();
        assertions++; if (n_frame != 1 || n_line != 6) begin failures++; $display("FAIL sof_counts: got %0d/%0d, expected 1/6", n_frame, n_line); end
        assertions++; if (qf.size() != 0) begin failures++; $display("FAIL sof_missing: %0d outstanding, expected 0", qf.size()); end
        prep();
        assertions++; if (e_sof !== 1'b0) begin failures++; $display("FAIL sof_clear: got %b, expected 0", e_sof); end
    endtask

    task automatic test_backpressure();
        prep();
        send_row(0, 0);
        for (int c = 0; c < 3; c++) beat(1'b0, 1'b0, 1);
        tdata  = 24'($urandom);
        tvalid = 1'b1;
        qf.push_back(1);
        qd.push_back(tdata);
        full1 = 1'b1;
        repeat (5) begin
            @(negedge Clk);
            assertions++; if (tready !== 1'b0 || wea1 !== 1'b0) begin failures++; $display("FAIL stall: tready %b wea1 %b, expected 0 0", tready, wea1); end
            @(posedge Clk);
            #1;
        end
        full1 = 1'b0;
        @(negedge Clk);
        assertions++; if (tready !== 1'b1) begin failures++; $display("FAIL stall_release: tready %b, expected 1", tready); end
        @(posedge Clk);
        #1;
        tvalid = 1'b0;
        for (int c = 4; c < H; c++) beat(1'b0, c == H - 1, 1);
        send_row(2, 0);
        send_row(3, 0);
        settle();
        assertions++; if (n_frame != 1 || n_line != 4 || qf.size() != 0) begin failures++; $display("FAIL stall_frame: frames %0d lines %0d outstanding %0d, expected 1 4 0", n_frame, n_line, qf.size()); end
    endtask

    task automatic test_reset_mid();
        prep();
        send_row(0, 0);
        send_row(1, 0);
        for (int c = 0; c < 4; c++) beat(1'b0, 1'b0, 0);
        tdata  = 24'($urandom);
        tvalid = 1'b1;
        Rst    = 1'b1;
        @(negedge Clk);
        assertions++; if (tready !== 1'b0 || {wea0, wea1} !== 2'b00) begin failures++; $display("FAIL rstmid_gate: tready %b wea %b, expected 0 00", tready, {wea0, wea1}); end
        @(posedge Clk);
        #1;
        assertions++; if (dut.state !== WAIT_SOF || dut.h_cnt !== 12'd0 || dut.v_cnt !== 12'd0) begin failures++; $display("FAIL rstmid_state: state %0d h %0d v %0d, expected WAIT_SOF 0 0", dut.state, dut.h_cnt, dut.v_cnt); end
        Rst    = 1'b0;
        tvalid = 1'b0;
        n_frame = 0;
        send_frame();
        settle();
        assertions++; if (n_frame != 1 || qf.size() != 0) begin failures++; $display("FAIL rstmid_recover: frames %0d outstanding %0d, expected 1 0", n_frame, qf.size()); end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_drop_no_sof();
        test_eol_early();
        test_eol_late();
        test_sof_mid();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
